// File: rtl/dpram_bank_ring_pkg.sv
// dpram_bank_ring_pkg
// Shared sizing helpers for the banked ring buffer.
//   idx_w(nb) : bits needed to hold a bank index 0..nb-1 (at least 1)
//   cnt_w(nb) : bits needed to hold a bank count 0..nb
//   N_DELAY_MAX : deepest supported read latency
package dpram_bank_ring_pkg;

    localparam int N_DELAY_MAX = 4;

    function automatic int idx_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    function automatic int cnt_w(input int nb);
        return $clog2(nb + 1);
    endfunction

endpackage

// File: rtl/dpram_bank.sv
// dpram_bank
// One DEPTH x DW dual-port RAM with per-byte write enables on port A and a
// registered (1-cycle) read on port B. Read data holds while re is low.
// Ports:
//   clk           clock
//   we            write strobe (caller guarantees addra < DEPTH)
//   wea   [BW]    per-byte write enable
//   addra [AW]    write word address
//   dia   [DW]    write data
//   re            read strobe (caller guarantees addrb < DEPTH)
//   addrb [AW]    read word address
//   dob   [DW]    registered read data
module dpram_bank #(
    parameter int DW    = 64,
    parameter int AW    = 8,
    parameter int DEPTH = 256,
    parameter int BW    = DW / 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [BW-1:0] wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dia,
    input  logic          re,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] dob
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BW; i++) begin
                if (wea[i]) begin
                    mem[addra][8*i +: 8] <= dia[8*i +: 8];
                end
            end
        end
        if (re) begin
            dob <= mem[addrb];
        end
    end

endmodule

// File: rtl/dpram_bank_ring.sv
// dpram_bank_ring
// NB dual-port banks used as a bank-granular ring buffer: the producer fills
// bank wbank and commits it, the consumer reads bank rbank and releases it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena, wea, addra, dia  write port (byte enables), into bank wbank
//   wr_commit           producer hands the current bank to the consumer
//   wr_ready            a free bank is available for writing
//   enb, addrb          read request from bank rbank
//   rd_release          consumer returns the current bank
//   rd_ready            a committed bank is available for reading
//   dob, dob_valid      read data, N_DELAY cycles after an accepted read
//   full_cnt            committed, unreleased banks
module dpram_bank_ring
    import dpram_bank_ring_pkg::*;
#(
    parameter int DW      = 64,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int NB      = 2,
    parameter int N_DELAY = 1,
    parameter int BW      = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [BW-1:0]        wea,
    input  logic [AW-1:0]        addra,
    input  logic [DW-1:0]        dia,
    input  logic                 wr_commit,
    output logic                 wr_ready,
    input  logic                 enb,
    input  logic [AW-1:0]        addrb,
    input  logic                 rd_release,
    output logic                 rd_ready,
    output logic [DW-1:0]        dob,
    output logic                 dob_valid,
    output logic [cnt_w(NB)-1:0] full_cnt
);

    localparam int IW = idx_w(NB);
    localparam int CW = cnt_w(NB);
    localparam logic [IW-1:0] LAST_BANK = IW'(NB - 1);
    localparam logic [CW-1:0] NB_CNT    = CW'(NB);
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);

    logic [IW-1:0] wbank;
    logic [IW-1:0] rbank;
    logic [CW-1:0] cnt;

    logic wr_acc;
    logic rd_acc;
    logic rd_oob;
    logic commit_ok;
    logic release_ok;

    function automatic logic [IW-1:0] next_bank(input logic [IW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    assign full_cnt   = cnt;
    assign wr_ready   = (cnt != NB_CNT);
    assign rd_ready   = (cnt != '0);
    assign wr_acc     = ena && wr_ready && ({1'b0, addra} < DEPTH_L);
    assign rd_acc     = enb && rd_ready;
    assign rd_oob     = !({1'b0, addrb} < DEPTH_L);
    assign commit_ok  = wr_commit && wr_ready;
    assign release_ok = rd_release && rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank <= '0;
            rbank <= '0;
            cnt   <= '0;
        end else begin
            if (commit_ok) begin
                wbank <= next_bank(wbank);
            end
            if (release_ok) begin
                rbank <= next_bank(rbank);
            end
            if (commit_ok && !release_ok) begin
                cnt <= cnt + 1'b1;
            end else if (!commit_ok && release_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // wbank == rbank only when all banks are empty or all full, so the
    // producer and consumer never touch the same bank.
    logic [DW-1:0] bank_dob [NB];

    for (genvar g = 0; g < NB; g++) begin : g_bank
        dpram_bank #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH),
            .BW    (BW)
        ) u_bank (
            .clk   (clk),
            .we    (wr_acc && (wbank == IW'(g))),
            .wea   (wea),
            .addra (addra),
            .dia   (dia),
            .re    (rd_acc && !rd_oob && (rbank == IW'(g))),
            .addrb (addrb),
            .dob   (bank_dob[g])
        );
    end

    // ---- stage p0: RAM read register, bank select and zero-force flag ----
    // zero_p0 resets to 1 so dob reads 0 out of reset without resetting RAM
    // output registers; out-of-range reads also force zero.
    logic          vld_p0;
    logic          zero_p0;
    logic [IW-1:0] rsel_p0;
    logic [DW-1:0] data_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            zero_p0 <= 1'b1;
            rsel_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) begin
                rsel_p0 <= rbank;
                zero_p0 <= rd_oob;
            end
        end
    end

    assign data_p0 = zero_p0 ? '0 : bank_dob[rsel_p0];

    // ---- stages p1..p(N_DELAY-1): data advances only with valid, so dob holds ----
    if (N_DELAY == 1) begin : g_nopipe
        assign dob       = data_p0;
        assign dob_valid = vld_p0;
    end else begin : g_pipe
        logic [DW-1:0]        data_q [N_DELAY-1];
        logic [N_DELAY-2:0]   vld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int k = 0; k < N_DELAY - 1; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                vld_q[0] <= vld_p0;
                if (vld_p0) begin
                    data_q[0] <= data_p0;
                end
                for (int k = 1; k < N_DELAY - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end

        assign dob       = data_q[N_DELAY-2];
        assign dob_valid = vld_q[N_DELAY-2];
    end

endmodule

// File: tb/tb_dpram_bank_ring.sv
// tb_dpram_bank_ring
// Directed bench for dpram_bank_ring with NB=2, DEPTH=200, N_DELAY=3.
module tb_dpram_bank_ring;

    localparam int DW      = 64;
    localparam int AW      = 8;
    localparam int DEPTH   = 200;
    localparam int NB      = 2;
    localparam int N_DELAY = 3;
    localparam int BW      = DW / 8;

    logic          clk;
    logic          rst;
    logic          ena;
    logic [BW-1:0] wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic          wr_commit;
    logic          wr_ready;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          rd_release;
    logic          rd_ready;
    logic [DW-1:0] dob;
    logic          dob_valid;
    logic [1:0]    full_cnt;

    int tests;
    int fails;

    localparam logic [63:0] B1W = 64'hB1B1_0000_0000_0001;
    localparam logic [63:0] C0W = 64'hC0C0_C0C0_0000_0007;
    localparam logic [63:0] D1W = 64'hD1D1_2222_3333_0009;
    localparam logic [63:0] BEW = 64'h1122_3344_FFFF_FFFF;

    dpram_bank_ring #(
        .DW      (DW),
        .AW      (AW),
        .DEPTH   (DEPTH),
        .NB      (NB),
        .N_DELAY (N_DELAY),
        .BW      (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wea        (wea),
        .addra      (addra),
        .dia        (dia),
        .wr_commit  (wr_commit),
        .wr_ready   (wr_ready),
        .enb        (enb),
        .addrb      (addrb),
        .rd_release (rd_release),
        .rd_ready   (rd_ready),
        .dob        (dob),
        .dob_valid  (dob_valid),
        .full_cnt   (full_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] word(input int k);
        return 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ena = 1'b0; wea = '0; addra = '0; dia = '0; wr_commit = 1'b0;
        enb = 1'b0; addrb = '0; rd_release = 1'b0;
    endtask

    task automatic write_word(input int a, input logic [63:0] d, input logic [7:0] be);
        ena = 1'b1; addra = AW'(a); dia = d; wea = be;
        tick();
        ena = 1'b0; wea = '0;
    endtask

    task automatic pulse_commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic pulse_release();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    task automatic read_expect(input string tag, input int a, input logic [63:0] exp);
        enb = 1'b1; addrb = AW'(a);
        tick();
        enb = 1'b0;
        check({tag, "_early_valid"}, dob_valid, 1'b0);
        tick();
        tick();
        check({tag, "_valid"}, dob_valid, 1'b1);
        check({tag, "_data"}, dob, exp);
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_rd_ready", rd_ready, 1'b0);
        check("rst_full_cnt", full_cnt, 2'd0);
        check("rst_dob_valid", dob_valid, 1'b0);
        check("rst_dob", dob, 64'h0);
        rst = 1'b0;
        tick();

        // Bank 0: pattern words at 0..4, byte-enable merge at 5
        for (int k = 0; k < 5; k++) write_word(k, word(k), 8'hFF);
        write_word(5, 64'h1122_3344_5566_7788, 8'hFF);
        write_word(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        check("pre_commit_rd_ready", rd_ready, 1'b0);
        pulse_commit();
        check("commit1_full_cnt", full_cnt, 2'd1);
        check("commit1_rd_ready", rd_ready, 1'b1);
        check("commit1_wr_ready", wr_ready, 1'b1);

        read_expect("rd_addr2", 2, word(2));
        check("hold_valid", dob_valid, 1'b0);
        check("hold_dob", dob, word(2));
        read_expect("rd_byte_en", 5, BEW);
        read_expect("rd_oob", 250, 64'h0);

        // Fill: bank 1 then commit, wbank wraps to 0
        write_word(0, B1W, 8'hFF);
        pulse_commit();
        check("full_cnt2", full_cnt, 2'd2);
        check("full_wr_ready", wr_ready, 1'b0);
        check("full_rd_ready", rd_ready, 1'b1);
        write_word(0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        pulse_commit();
        check("full_commit_ignored", full_cnt, 2'd2);
        read_expect("full_write_ignored", 0, word(0));

        // Back-to-back reads 0..4, release with the last one
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                enb = 1'b1; addrb = AW'(c);
                rd_release = (c == 4);
            end else begin
                enb = 1'b0; rd_release = 1'b0;
            end
            tick();
            if (c >= 2) begin
                check($sformatf("b2b_valid%0d", c), dob_valid, 1'b1);
                check($sformatf("b2b_data%0d", c), dob, word(c - 2));
            end else begin
                check($sformatf("b2b_valid%0d", c), dob_valid, 1'b0);
            end
        end
        check("release_full_cnt", full_cnt, 2'd1);
        check("release_wr_ready", wr_ready, 1'b1);

        // Commit + release + write + read in one cycle at full_cnt=1
        ena = 1'b1; wea = 8'hFF; addra = 8'd7; dia = C0W;
        wr_commit = 1'b1; rd_release = 1'b1;
        enb = 1'b1; addrb = 8'd0;
        tick();
        idle();
        check("both_full_cnt", full_cnt, 2'd1);
        tick();
        tick();
        check("both_old_rbank_valid", dob_valid, 1'b1);
        check("both_old_rbank_data", dob, B1W);
        tick();
        read_expect("rbank_wrap", 7, C0W);

        write_word(9, D1W, 8'hFF);
        pulse_commit();
        check("wbank_adv_full_cnt", full_cnt, 2'd2);
        pulse_release();
        check("rel_full_cnt", full_cnt, 2'd1);
        read_expect("wbank_adv_data", 9, D1W);
        pulse_release();
        check("empty_full_cnt", full_cnt, 2'd0);
        check("empty_rd_ready", rd_ready, 1'b0);

        // Reads while empty produce nothing
        enb = 1'b1; addrb = 8'd9;
        tick();
        tick();
        enb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("empty_rd_valid%0d", c), dob_valid, 1'b0);
        end
        check("empty_rd_dob_hold", dob, D1W);

        // Reset with two reads in flight
        pulse_commit();
        enb = 1'b1; addrb = 8'd0;
        tick();
        addrb = 8'd1;
        tick();
        enb = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_dob_valid", dob_valid, 1'b0);
        check("arst_dob", dob, 64'h0);
        check("arst_full_cnt", full_cnt, 2'd0);
        check("arst_rd_ready", rd_ready, 1'b0);
        check("arst_wr_ready", wr_ready, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("arst_late_valid%0d", c), dob_valid, 1'b0);
        end
        check("arst_dob_after", dob, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
